screen_sequencer: RTL and testbench

Control FSM that generates the 4-bit step code feeding the screen counter. The screen counter advances on step == 4'b0011; its enable output selects screen 1..4.
- Turns a raw "next" button, or an automatic frame-count timer, into exactly one single-cycle ADVANCE step per request.
- ADVANCE is aligned to the VGA timing's frame_start pulse, so screen changes never tear mid-frame.
- Sits between board buttons, VGA timing generator and screen counter.

---
 rtl/vga_ctrl_pkg.sv | 18 +
 rtl/screen_sequencer_if.sv | 23 ++
 rtl/button_debounce.sv | 55 +++++
 rtl/screen_sequencer.sv | 106 ++++++++++
 tb/tb_screen_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_ctrl_pkg.sv
// Shared step codes for the screen sequencer and the screen counter it feeds.
// The step code doubles as the sequencer's FSM state encoding.
package vga_ctrl_pkg;

    localparam logic [3:0] STEP_ADVANCE_CODE = 4'b0011;

    typedef enum logic [3:0] {
        STEP_IDLE    = 4'b0000,
        STEP_ARMED   = 4'b0001,
        STEP_ADVANCE = STEP_ADVANCE_CODE,
        STEP_HOLD    = 4'b0010
    } step_t;

    function automatic logic step_is_busy(input step_t s);
        return (s == STEP_ARMED) || (s == STEP_ADVANCE);
    endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Button, frame-timing and step/status signals between the board, the VGA timing
// generator, the screen counter and the sequencer.
interface screen_sequencer_if;
    import vga_ctrl_pkg::*;

    logic  btn_next;
    logic  btn_auto;
    logic  frame_start;
    step_t step;
    logic  busy;
    logic  auto_mode;

    modport master (
        output btn_next, btn_auto, frame_start,
        input  step, busy, auto_mode
    );

    modport slave (
        input  btn_next, btn_auto, frame_start,
        output step, busy, auto_mode
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stable-sample debounce and rising-edge press pulse
// for one raw push button.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The sample that would bring the count to DEBOUNCE_CYCLES flips the level directly.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/screen_sequencer.sv
// Turns manual or frame-timed auto requests into a single ADVANCE step code,
// aligned to the next frame_start so screen changes never tear.
module screen_sequencer
    import vga_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int AUTO_FRAMES     = 120
) (
    input logic               clk,
    input logic               rst,
    screen_sequencer_if.slave bus_if
);

    localparam int FW = $clog2(AUTO_FRAMES + 1);

    logic [1:0] raw_vec, level_vec, press_vec;
    logic       next_level, next_press, auto_press, auto_level_unused;

    assign raw_vec = {bus_if.btn_auto, bus_if.btn_next};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw_vec[gi]),
                .level(level_vec[gi]),
                .press(press_vec[gi])
            );
        end
    endgenerate

    assign next_level        = level_vec[0];
    assign next_press        = press_vec[0];
    assign auto_level_unused = level_vec[1];
    assign auto_press        = press_vec[1];

    step_t         state_q, state_d;
    logic          manual_q, manual_d;
    logic          auto_q, auto_d;
    logic          busy_q, busy_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          auto_req;

    assign auto_req = auto_q && (frame_cnt_q == FW'(AUTO_FRAMES));

    always_comb begin
        state_d     = state_q;
        manual_d    = manual_q;
        auto_d      = auto_q ^ auto_press;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            // A frame_start coinciding with the request is deliberately not used.
            STEP_IDLE: begin
                if (next_press || auto_req) begin
                    state_d  = STEP_ARMED;
                    manual_d = next_press;
                end
            end
            STEP_ARMED: begin
                if (bus_if.frame_start) state_d = STEP_ADVANCE;
            end
            STEP_ADVANCE: begin
                state_d = manual_q ? STEP_HOLD : STEP_IDLE;
            end
            STEP_HOLD: begin
                if (!next_level) state_d = STEP_IDLE;
            end
            default: state_d = STEP_IDLE;
        endcase

        // Saturate at AUTO_FRAMES so a pending auto request cannot wrap away.
        if (!auto_q || state_d == STEP_ADVANCE) begin
            frame_cnt_d = '0;
        end else if (state_q == STEP_IDLE && bus_if.frame_start &&
                     frame_cnt_q != FW'(AUTO_FRAMES)) begin
            frame_cnt_d = frame_cnt_q + FW'(1);
        end

        busy_d = step_is_busy(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STEP_IDLE;
            manual_q    <= 1'b0;
            auto_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            manual_q    <= manual_d;
            auto_q      <= auto_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus_if.step      = state_q;
    assign bus_if.busy      = busy_q;
    assign bus_if.auto_mode = auto_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer (DEBOUNCE_CYCLES=4, AUTO_FRAMES=3); expected
// output changes with their clock index are queued and checked by a monitor.
module tb_screen_sequencer;
    import vga_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    screen_sequencer_if sif ();

    screen_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_FRAMES    (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_if(sif)
    );

    typedef struct {
        logic [3:0] step;
        logic       busy;
        logic       am;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] last_obs;

    task automatic expect_ev(input logic [3:0] s, input logic b, input logic a, input int c);
        exp_t e;
        e.step = s;
        e.busy = b;
        e.am   = a;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end else begin
            $display("check %s ok: %0d", nm, act);
        end
    endtask

    // Monitor: any change of {step,busy,auto_mode} outside reset is one transaction.
    always @(negedge clk) begin
        logic [5:0] obs;
        exp_t       e;
        obs = {sif.step, sif.busy, sif.auto_mode};
        if (rst) begin
            last_obs = obs;
        end else if (obs != last_obs) begin
            last_obs = obs;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d step=%b busy=%b auto=%b, required no change",
                         cyc, obs[5:2], obs[1], obs[0]);
            end else begin
                e = exp_q.pop_front();
                if (obs != {e.step, e.busy, e.am} || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL event: got cyc=%0d step=%b busy=%b auto=%b, required cyc=%0d step=%b busy=%b auto=%b",
                             cyc, obs[5:2], obs[1], obs[0], e.cyc, e.step, e.busy, e.am);
                end else begin
                    $display("event cyc=%0d step=%b busy=%b auto=%b ok", cyc, obs[5:2], obs[1], obs[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic frame_pulse();
        sif.frame_start = 1'b1;
        tick();
        sif.frame_start = 1'b0;
    endtask

    // Clean press: ARMED 8 clocks after the rise, frame_start at +10 gives ADVANCE at +11,
    // HOLD at +12, release at +20 debounced so IDLE at +27.
    task automatic do_manual(input logic am);
        int t0;
        t0 = cyc;
        expect_ev(STEP_ARMED,   1'b1, am, t0 + 8);
        expect_ev(STEP_ADVANCE, 1'b1, am, t0 + 11);
        expect_ev(STEP_HOLD,    1'b0, am, t0 + 12);
        expect_ev(STEP_IDLE,    1'b0, am, t0 + 27);
        sif.btn_next = 1'b1;
        wait_until(t0 + 10);
        frame_pulse();
        wait_until(t0 + 20);
        sif.btn_next = 1'b0;
        wait_until(t0 + 35);
    endtask

    task automatic toggle_auto(input logic new_am);
        int t0;
        t0 = cyc;
        expect_ev(STEP_IDLE, 1'b0, new_am, t0 + 8);
        sif.btn_auto = 1'b1;
        wait_until(t0 + 10);
        sif.btn_auto = 1'b0;
        wait_until(t0 + 20);
    endtask

    initial begin
        int t0, t1;
        sif.btn_next    = 1'b0;
        sif.btn_auto    = 1'b0;
        sif.frame_start = 1'b0;
        rst             = 1'b1;
        repeat (3) tick();
        check("reset_step", int'(sif.step), 0);
        check("reset_busy", int'(sif.busy), 0);
        check("reset_auto", int'(sif.auto_mode), 0);
        rst = 1'b0;
        tick();

        do_manual(1'b0);

        // Bounce: toggling every 2 clocks never stays stable for 4 samples.
        for (int i = 0; i < 4; i++) begin
            sif.btn_next = 1'b1;
            tick();
            tick();
            sif.btn_next = 1'b0;
            tick();
            tick();
        end
        repeat (20) tick();
        check("bounce_step", int'(sif.step), 0);

        // Second press while ARMED must not queue another advance.
        t0 = cyc;
        expect_ev(STEP_ARMED,   1'b1, 1'b0, t0 + 8);
        expect_ev(STEP_ADVANCE, 1'b1, 1'b0, t0 + 33);
        expect_ev(STEP_HOLD,    1'b0, 1'b0, t0 + 34);
        expect_ev(STEP_IDLE,    1'b0, 1'b0, t0 + 47);
        sif.btn_next = 1'b1;
        wait_until(t0 + 12);
        sif.btn_next = 1'b0;
        wait_until(t0 + 20);
        sif.btn_next = 1'b1;
        wait_until(t0 + 32);
        frame_pulse();
        wait_until(t0 + 40);
        sif.btn_next = 1'b0;
        wait_until(t0 + 55);

        // Press pulse coincides with frame_start: advance waits for the next frame.
        t0 = cyc;
        expect_ev(STEP_ARMED,   1'b1, 1'b0, t0 + 8);
        expect_ev(STEP_ADVANCE, 1'b1, 1'b0, t0 + 16);
        expect_ev(STEP_HOLD,    1'b0, 1'b0, t0 + 17);
        expect_ev(STEP_IDLE,    1'b0, 1'b0, t0 + 32);
        sif.btn_next = 1'b1;
        wait_until(t0 + 7);
        frame_pulse();
        wait_until(t0 + 15);
        frame_pulse();
        wait_until(t0 + 25);
        sif.btn_next = 1'b0;
        wait_until(t0 + 40);

        // Auto mode: ARMED after every 3rd counted frame, ADVANCE on the 4th.
        toggle_auto(1'b1);
        t1 = cyc;
        expect_ev(STEP_ARMED,   1'b1, 1'b1, t1 + 150 + 2);
        expect_ev(STEP_ADVANCE, 1'b1, 1'b1, t1 + 200 + 1);
        expect_ev(STEP_IDLE,    1'b0, 1'b1, t1 + 200 + 2);
        expect_ev(STEP_ARMED,   1'b1, 1'b1, t1 + 350 + 2);
        expect_ev(STEP_ADVANCE, 1'b1, 1'b1, t1 + 400 + 1);
        expect_ev(STEP_IDLE,    1'b0, 1'b1, t1 + 400 + 2);
        for (int k = 1; k <= 8; k++) begin
            wait_until(t1 + 50 * k);
            frame_pulse();
        end
        toggle_auto(1'b0);
        t1 = cyc;
        for (int k = 1; k <= 4; k++) begin
            wait_until(t1 + 50 * k);
            frame_pulse();
        end
        repeat (10) tick();
        check("auto_off_step", int'(sif.step), 0);

        // Reset while ARMED (auto on) clears everything at once and drops the request.
        toggle_auto(1'b1);
        t1 = cyc;
        expect_ev(STEP_ARMED, 1'b1, 1'b1, t1 + 8);
        sif.btn_next = 1'b1;
        wait_until(t1 + 12);
        sif.btn_next = 1'b0;
        wait_until(t1 + 20);
        rst = 1'b1;
        #1;
        check("rst_mid_step", int'(sif.step), 0);
        check("rst_mid_busy", int'(sif.busy), 0);
        check("rst_mid_auto", int'(sif.auto_mode), 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        repeat (5) tick();
        frame_pulse();
        repeat (10) tick();
        frame_pulse();
        repeat (10) tick();
        do_manual(1'b0);

        repeat (5) tick();
        check("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
